// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher receive datapath: command codes,
// FSM states, key geometry, LFSR tap mask and the uio output-enable mask.
package xor_cipher_pkg;

  typedef enum logic [1:0] {
    CMD_DATA   = 2'b00,
    CMD_KEY    = 2'b01,
    CMD_RESYNC = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_NOKEY   = 2'b00,
    ST_LOADING = 2'b01,
    ST_READY   = 2'b10
  } state_e;

  localparam int KEY_BYTES = 4;

  // Last value of the 2-bit load counter before the key is complete.
  localparam logic [1:0] LAST_LOAD = 2'(KEY_BYTES - 1);

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: feedback is the XOR
  // of register bits 7,5,4,3 and enters at bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Next state of the keystream LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/xor_keystream.sv
// Key shift register, rolling byte index and (with XOR_LFSR_EN defined)
// the 8-bit whitening LFSR. Presents the current keystream byte.
module xor_keystream
  import xor_cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_shift,
  input  logic [7:0] key_byte,
  input  logic       idx_clear,
  input  logic       idx_advance,
  output logic [7:0] ks_byte
);

  logic [31:0] key_q;
  logic [1:0]  idx_q;
  logic [7:0]  key_sel;

  // Key bytes enter at the bottom so the first byte ends in key[31:24].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (key_shift) begin
      key_q <= {key_q[23:0], key_byte};
    end
  end

  // Byte index: cleared on key completion / resync, wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (idx_clear) begin
      idx_q <= '0;
    end else if (idx_advance) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Select keybyte[idx], index 0 being the most significant byte.
  always_comb begin
    key_sel = key_q[31:24];
    case (idx_q)
      2'd0: key_sel = key_q[31:24];
      2'd1: key_sel = key_q[23:16];
      2'd2: key_sel = key_q[15:8];
      2'd3: key_sel = key_q[7:0];
      default: key_sel = key_q[31:24];
    endcase
  end

`ifdef XOR_LFSR_EN
  logic [7:0] lfsr_q;
  logic [7:0] seed;

  // On key completion the final key byte is still being shifted in, so the
  // seed must come from the incoming byte rather than the stale register.
  assign seed = (key_shift ? key_byte : key_q[7:0]) | 8'h01;

  // LFSR: reseeded alongside the index clear, stepped after each data byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 8'h01;
    end else if (idx_clear) begin
      lfsr_q <= seed;
    end else if (idx_advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign ks_byte = key_sel ^ lfsr_q;
`else
  assign ks_byte = key_sel;
`endif

endmodule

// File: rtl/xor_decipher_rx.sv
// Tiny Tapeout receive-side XOR decryptor. Strobe synchronizer, rising-edge
// accept, NOKEY/LOADING/READY control FSM and registered outputs.
// Optional build macro: XOR_LFSR_EN adds LFSR whitening to the keystream.
//
// Handshake: the sender raises uio_in[0] with ui_in and uio_in[2:1] already
// stable and holds all three until the strobe falls; each synchronized
// rising edge (while ena is high) is one accepted byte. There is no
// back-pressure; out_valid is a one-cycle pulse with uo_out held afterwards.
module xor_decipher_rx
  import xor_cipher_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev_q;
  logic                   accept;
  cmd_e                   cmd;

  state_e     state_q;
  logic [1:0] load_cnt_q;
  logic [7:0] data_q;
  logic       out_valid_q;
  logic       err_q;

  logic       key_shift;
  logic       key_done;
  logic       idx_clear;
  logic       idx_advance;
  logic [7:0] ks_byte;
  logic       unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:3]};

  // Strobe synchronizer and edge-detect history; runs regardless of ena so
  // an edge seen while deselected is consumed and lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign accept = ena & sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign cmd    = cmd_e'(uio_in[2:1]);

  assign key_shift   = accept && (cmd == CMD_KEY);
  assign key_done    = key_shift && (state_q == ST_LOADING) && (load_cnt_q == LAST_LOAD);
  assign idx_clear   = key_done ||
                       (accept && (cmd == CMD_RESYNC) && (state_q == ST_READY));
  assign idx_advance = accept && (cmd == CMD_DATA) && (state_q == ST_READY);

  xor_keystream u_keystream (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_shift   (key_shift),
    .key_byte    (ui_in),
    .idx_clear   (idx_clear),
    .idx_advance (idx_advance),
    .ks_byte     (ks_byte)
  );

  // Control FSM with registered plaintext, valid pulse and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_NOKEY;
      load_cnt_q  <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        case (cmd)
          CMD_KEY: begin
            if (state_q == ST_LOADING) begin
              if (load_cnt_q == LAST_LOAD) begin
                state_q    <= ST_READY;
                load_cnt_q <= '0;
                err_q      <= 1'b0;
              end else begin
                load_cnt_q <= load_cnt_q + 2'd1;
              end
            end else begin
              state_q    <= ST_LOADING;
              load_cnt_q <= 2'd1;
            end
          end
          CMD_DATA: begin
            if (state_q == ST_READY) begin
              data_q      <= ui_in ^ ks_byte;
              out_valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          CMD_RESYNC: begin
            // In READY only the keystream realigns; see idx_clear.
            if (state_q == ST_LOADING) begin
              state_q    <= ST_NOKEY;
              load_cnt_q <= '0;
            end
          end
          default: err_q <= 1'b1;
        endcase
      end
    end
  end

  assign uo_out  = data_q;
  assign uio_out = {(state_q == ST_LOADING), err_q, (state_q == ST_READY),
                    out_valid_q, 4'b0000};
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: doc/xor_decipher_rx.md
# xor_decipher_rx

Receive-side decryptor for the team's XOR cipher link, built as a Tiny Tapeout user module. It accepts strobed ciphertext bytes from the pins, loads a 32-bit key through the same byte path, and XORs each data byte with a rolling key byte to recover plaintext on `uo_out`. The result is the decryption end of the XOR-cipher datapath, with a sticky protocol-error flag.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on the strobe input; must be ≥2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `ena`  in  1  design selected; when low, no strobes are accepted and all state holds.
- `ui_in`  in  8  ciphertext byte or key byte.
- `uio_in`  in  8  control inputs:
  - [0]: strobe.
  - [2:1]: command. 00 DATA, 01 KEY, 10 RESYNC, 11 reserved.
  - [7:3]: ignored.
- `uo_out`  out  8  plaintext byte, registered.
- `uio_out`  out  8  status outputs:
  - [4]: `out_valid`, a one-cycle pulse.
  - [5]: `key_ready`.
  - [6]: `err`, sticky.
  - [7]: `loading`.
  - [3:0]: 0.
- `uio_oe`  out  8  constant 8'hF0.

## Operation
- The strobe is synchronized through `SYNC_STAGES` flops. A rising edge of the synchronized strobe is an accept event.
- On an accept event, `ui_in` and `uio_in[2:1]` are sampled directly. The sender holds them stable for the whole strobe-high period.
- FSM states:
  - NOKEY: reset state.
  - LOADING
  - READY
- KEY command:
  - Shifts `ui_in` into the key register, MSB byte first, so the first byte lands in key[31:24].
  - In NOKEY or READY: go to LOADING with load count 1. `key_ready` drops.
  - In LOADING: increment the load count.
  - On the 4th byte: go to READY, clear the byte index, reseed the LFSR if present, clear `err`.
- DATA command:
  - In READY: `uo_out` = `ui_in` ^ keybyte[idx]. keybyte[0] = key[31:24] … keybyte[3] = key[7:0]. `out_valid` pulses; idx increments and wraps 3→0.
  - In NOKEY or LOADING: the byte is dropped, no `out_valid`, `err` is set.
- RESYNC command:
  - In READY: idx is cleared and the LFSR is reseeded; no output.
  - In LOADING: the load is aborted and the FSM goes to NOKEY. The key contents are retained but not valid.
  - In NOKEY: no effect.
- Command 11: ignored, `err` set.
- Output flags:
  - `loading` = state==LOADING.
  - `key_ready` = state==READY.
- `uo_out` holds its last value between outputs.
- When `ena` is low, accept events are suppressed. Synchronizer flops still run, so a strobe edge occurring while `ena` is low is lost.
- Reset values:
  - `uo_out` 0
  - `out_valid` 0
  - `key_ready` 0
  - `err` 0
  - `loading` 0
  - key 0
  - idx 0
  - load count 0
  - synchronizer 0
  - FSM NOKEY
- Reset asserted mid-load or mid-stream discards everything and returns to NOKEY.

## Timing
- Strobe sampled high first at edge N → accept at edge N+`SYNC_STAGES`. `uo_out` and `out_valid` are valid in the following cycle; `out_valid` is high for exactly one cycle.
- Status flags update at the same edge as the accept.
- Minimum strobe high and low times are each `SYNC_STAGES`+1 cycles. A strobe held high yields exactly one accept.
- Maximum throughput: one byte per 2×(`SYNC_STAGES`+1) cycles.

## Configuration
- `XOR_LFSR_EN` defined:
  - Keystream byte = keybyte[idx] ^ lfsr.
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Seed = key[7:0] | 8'h01, loaded on key completion and on RESYNC.
  - Advances once per accepted DATA byte, after use.
- `XOR_LFSR_EN` undefined: the LFSR logic is absent; keystream = keybyte[idx] only.

## Structure
- Package `xor_cipher_pkg` holds:
  - command encodings
  - FSM state enum
  - `KEY_BYTES`=4
  - LFSR polynomial/tap mask
  - `UIO_OE_MASK`=8'hF0
- Sub-module `xor_keystream` holds:
  - key shift register
  - idx counter
  - optional LFSR
  - Outputs the current keystream byte.
- Top level holds:
  - synchronizer
  - edge detect
  - FSM
  - output registers

## Test plan
- Macro off, key DE AD BE EF loaded, then DATA 00 ×5 → `uo_out` DE, AD, BE, EF, DE; five `out_valid` pulses; `key_ready`=1 after the 4th key byte.
- DATA 0x55 before any key → no `out_valid`, `err`=1. Then load a full key → `err`=0, `key_ready`=1.
- Key DE AD BE EF; DATA 00, 00; RESYNC; DATA 00 → DE, AD, then DE; RESYNC produces no `out_valid`.
- KEY 11, 22, then RESYNC → `loading`=0, `key_ready`=0. A following DATA sets `err` with no output.
- Reset mid-stream after 2 outputs → all outputs 0 and NOKEY at the next cycle. Strobe held high for 20 cycles → exactly one accept.
- Macro on, key 00 00 00 00, DATA 00 ×3 → 01, then the next two LFSR states from seed 0x01. The ena-low test runs with the macro off: with `ena`=0, a strobe is ignored and no state changes.
